// File: rtl/mult_arbiter_pkg.sv
// Shared constants and helpers for the multiplier arbiter slice.
package mult_arbiter_pkg;

    localparam int DEF_DATA_LEN     = 32;
    localparam int DEF_NUM_REQ      = 4;
    localparam int DEF_MULT_LATENCY = 1;
    localparam int DEF_FIFO_DEPTH   = 4;

    // Index width for n entries, never narrower than one bit.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mult_arbiter_mult.sv
// Pipelined multiplier: LATENCY register stages, low WIDTH bits of the product.
module mult_arbiter_mult #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] p
);

    logic [WIDTH-1:0] prod;
    logic [WIDTH-1:0] pipe_d [LATENCY];
    logic [WIDTH-1:0] pipe_q [LATENCY];

    // Low bits of a two's complement product do not depend on signedness.
    assign prod = a * b;

    always_comb begin
        pipe_d[0] = prod;
        for (int i = 1; i < LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign p = pipe_q[LATENCY-1];

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one pipelined multiplier among NUM_REQ
// requesters, with an ordered response FIFO.
module mult_arbiter
    import mult_arbiter_pkg::*;
#(
    parameter int DATA_LEN     = DEF_DATA_LEN,
    parameter int NUM_REQ      = DEF_NUM_REQ,
    parameter int MULT_LATENCY = DEF_MULT_LATENCY,
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_LEN-1:0]   req_a,
    input  logic [NUM_REQ*DATA_LEN-1:0]   req_b,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [id_width(NUM_REQ)-1:0]  resp_id,
    output logic [DATA_LEN-1:0]           resp_data,
    output logic                          busy
);

    localparam int ID_W  = id_width(NUM_REQ);
    localparam int PTR_W = id_width(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1) + 1;

    logic [ID_W-1:0]         rr_ptr_d, rr_ptr_q;
    logic [ID_W-1:0]         arb_cand;
    logic                    grant_vld;
    logic [ID_W-1:0]         grant_idx;
    logic                    issue_ok;
    logic                    accept;
    logic [DATA_LEN-1:0]     op_a, op_b, mult_p;
    logic                    mult_rst;

    logic [MULT_LATENCY-1:0] tag_vld_d, tag_vld_q;
    logic [ID_W-1:0]         tag_id_d [MULT_LATENCY];
    logic [ID_W-1:0]         tag_id_q [MULT_LATENCY];
    logic [CNT_W-1:0]        inflight_cnt;

    logic                    push, pop;
    logic [PTR_W-1:0]        wr_ptr_d, wr_ptr_q;
    logic [PTR_W-1:0]        rd_ptr_d, rd_ptr_q;
    logic [CNT_W-1:0]        fifo_count_d, fifo_count_q;
    logic [ID_W-1:0]         fifo_id_mem   [FIFO_DEPTH];
    logic [DATA_LEN-1:0]     fifo_data_mem [FIFO_DEPTH];

    // rr_ptr_q is the first index searched, i.e. one past the last grant.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        arb_cand  = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            arb_cand = ID_W'((int'(rr_ptr_q) + off) % NUM_REQ);
            if (!grant_vld && req_valid[arb_cand]) begin
                grant_vld = 1'b1;
                grant_idx = arb_cand;
            end
        end
    end

    // Credit check counts results still in the multiplier as occupied slots.
    assign issue_ok = (fifo_count_q + inflight_cnt) < CNT_W'(FIFO_DEPTH);
    assign accept   = reset & grant_vld & issue_ok;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                op_a = req_a[i*DATA_LEN +: DATA_LEN];
                op_b = req_b[i*DATA_LEN +: DATA_LEN];
            end
        end
    end

    assign mult_rst = ~reset;

    mult_arbiter_mult #(
        .WIDTH   (DATA_LEN),
        .LATENCY (MULT_LATENCY)
    ) u_mult (
        .clk (clk),
        .rst (mult_rst),
        .a   (op_a),
        .b   (op_b),
        .p   (mult_p)
    );

    always_comb begin
        tag_vld_d    = '0;
        tag_vld_d[0] = accept;
        tag_id_d[0]  = grant_idx;
        for (int i = 1; i < MULT_LATENCY; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_id_d[i]  = tag_id_q[i-1];
        end
    end

    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i < MULT_LATENCY; i++) begin
            inflight_cnt = inflight_cnt + CNT_W'(tag_vld_q[i]);
        end
    end

    assign push = tag_vld_q[MULT_LATENCY-1];
    assign pop  = resp_valid & resp_ready;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fifo_count_d = fifo_count_q + CNT_W'(push) - CNT_W'(pop);
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_q     <= '0;
            tag_vld_q    <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
            for (int i = 0; i < MULT_LATENCY; i++) begin
                tag_id_q[i] <= '0;
            end
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            tag_vld_q    <= tag_vld_d;
            tag_id_q     <= tag_id_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_count_q <= fifo_count_d;
        end
    end

    // Storage needs no reset: the head is masked whenever the count is zero.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_id_mem[wr_ptr_q]   <= tag_id_q[MULT_LATENCY-1];
            fifo_data_mem[wr_ptr_q] <= mult_p;
        end
    end

    assign resp_valid = (fifo_count_q != '0);
    assign resp_id    = resp_valid ? fifo_id_mem[rd_ptr_q] : '0;
    assign resp_data  = resp_valid ? fifo_data_mem[rd_ptr_q] : '0;
    assign busy       = (inflight_cnt != '0) || (fifo_count_q != '0);

endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench for mult_arbiter at default parameters.
module tb_mult_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_a, req_b;
    logic         resp_valid;
    logic         resp_ready;
    logic [1:0]   resp_id;
    logic [31:0]  resp_data;
    logic         busy;

    logic [31:0] a_v [4];
    logic [31:0] b_v [4];

    typedef struct { logic [1:0] id; logic [31:0] data; } exp_t;
    typedef struct {
        bit extra;
        logic [1:0] eid, gid;
        logic [31:0] edata, gdata;
    } res_t;

    exp_t exp_q[$];
    res_t res_q[$];
    int   acc_q[$];
    int   checks = 0;
    int   errors = 0;

    assign req_a = {a_v[3], a_v[2], a_v[1], a_v[0]};
    assign req_b = {b_v[3], b_v[2], b_v[1], b_v[0]};

    always #5 clk = ~clk;

    mult_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .busy       (busy)
    );

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return p[31:0];
    endfunction

    // Samples at the falling edge: logs accepts into the scoreboard and
    // pairs each popped response with the oldest expected entry.
    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                exp_t e;
                e.id   = 2'(i);
                e.data = model(a_v[i], b_v[i]);
                exp_q.push_back(e);
                acc_q.push_back(i);
            end
        end
        if (resp_valid && resp_ready) begin
            res_t r;
            r.extra = (exp_q.size() == 0);
            r.eid   = '0;
            r.edata = '0;
            if (!r.extra) begin
                r.eid   = exp_q[0].id;
                r.edata = exp_q[0].data;
                void'(exp_q.pop_front());
            end
            r.gid   = resp_id;
            r.gdata = resp_data;
            res_q.push_back(r);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        acc_q.delete();
        res_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req_valid = 4'hF;
        resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_v[i] = 32'(i + 1);
            b_v[i] = 32'(i + 2);
        end
        #3;
        checks++;
        if (req_ready !== 4'b0 || resp_valid !== 1'b0 || resp_id !== 2'd0 ||
            resp_data !== 32'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got ready=%b rv=%b id=%0d data=%h busy=%b, need all zero",
                     req_ready, resp_valid, resp_id, resp_data, busy);
        end
        req_valid = 4'h0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
    endtask

    task automatic test_round_robin();
        int exp_ids[5] = '{0, 1, 2, 3, 0};
        clear_logs();
        req_valid = 4'hF;
        for (int i = 0; i < 4; i++) begin
            a_v[i] = 32'(10 + i);
            b_v[i] = 32'(-(i + 1));
        end
        repeat (5) tick();
        req_valid = 4'h0;
        repeat (6) tick();
        checks++;
        if (acc_q.size() != 5) begin
            errors++;
            $display("FAIL rr_accepts: got %0d accepts in 5 cycles, need 5", acc_q.size());
        end
        for (int i = 0; i < 5 && i < acc_q.size(); i++) begin
            checks++;
            if (acc_q[i] != exp_ids[i]) begin
                errors++;
                $display("FAIL rr_grant[%0d]: got %0d need %0d", i, acc_q[i], exp_ids[i]);
            end
        end
        checks++;
        if (res_q.size() != 5) begin
            errors++;
            $display("FAIL rr_resp_count: got %0d need 5", res_q.size());
        end
        foreach (res_q[i]) begin
            checks++;
            if (res_q[i].extra || res_q[i].gid !== res_q[i].eid ||
                res_q[i].gdata !== res_q[i].edata) begin
                errors++;
                $display("FAIL rr_resp[%0d]: got id=%0d data=%h need id=%0d data=%h extra=%0b",
                         i, res_q[i].gid, res_q[i].gdata, res_q[i].eid, res_q[i].edata, res_q[i].extra);
            end
        end
    endtask

    task automatic test_single();
        clear_logs();
        resp_ready = 1'b1;
        a_v[2] = 32'd7;
        b_v[2] = -32'sd3;
        req_valid = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL single_ready: got %b need 0100", req_ready);
        end
        tick();
        req_valid = 4'h0;
        checks++;
        if (resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_early: resp_valid got %b need 0 one cycle after accept", resp_valid);
        end
        tick();
        checks++;
        if (resp_valid !== 1'b1 || resp_id !== 2'd2 || resp_data !== 32'hFFFF_FFEB) begin
            errors++;
            $display("FAIL single_resp: got v=%b id=%0d data=%h need v=1 id=2 data=ffffffeb",
                     resp_valid, resp_id, resp_data);
        end
        repeat (3) tick();
        checks++;
        if (res_q.size() != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_drain: got %0d responses busy=%b need 1 and busy=0",
                     res_q.size(), busy);
        end
    endtask

    task automatic test_backpressure();
        int n0;
        clear_logs();
        resp_ready = 1'b0;
        req_valid = 4'b0001;
        b_v[0] = 32'd3;
        for (int k = 1; k <= 8; k++) begin
            a_v[0] = 32'(k);
            tick();
        end
        checks++;
        if (acc_q.size() != 4) begin
            errors++;
            $display("FAIL bp_accepts: got %0d need 4", acc_q.size());
        end
        checks++;
        if (req_ready !== 4'b0 || busy !== 1'b1 || resp_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_full: got ready=%b busy=%b rv=%b need 0000 1 1",
                     req_ready, busy, resp_valid);
        end
        n0 = acc_q.size();
        resp_ready = 1'b1;
        for (int k = 20; k < 26; k++) begin
            a_v[0] = 32'(k);
            tick();
        end
        req_valid = 4'h0;
        repeat (8) tick();
        checks++;
        if (acc_q.size() <= n0) begin
            errors++;
            $display("FAIL bp_resume: got %0d accepts need more than %0d", acc_q.size(), n0);
        end
        for (int i = 0; i < 4 && i < res_q.size(); i++) begin
            checks++;
            if (res_q[i].gdata !== 32'(3 * (i + 1)) || res_q[i].gid !== 2'd0) begin
                errors++;
                $display("FAIL bp_order[%0d]: got id=%0d data=%h need id=0 data=%h",
                         i, res_q[i].gid, res_q[i].gdata, 32'(3 * (i + 1)));
            end
        end
        checks++;
        if (res_q.size() != acc_q.size() || exp_q.size() != 0) begin
            errors++;
            $display("FAIL bp_count: got %0d responses for %0d accepts, %0d left",
                     res_q.size(), acc_q.size(), exp_q.size());
        end
        foreach (res_q[i]) begin
            checks++;
            if (res_q[i].extra || res_q[i].gid !== res_q[i].eid ||
                res_q[i].gdata !== res_q[i].edata) begin
                errors++;
                $display("FAIL bp_resp[%0d]: got id=%0d data=%h need id=%0d data=%h",
                         i, res_q[i].gid, res_q[i].gdata, res_q[i].eid, res_q[i].edata);
            end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] need[2] = '{32'h0000_0000, 32'h0000_0001};
        clear_logs();
        resp_ready = 1'b1;
        req_valid = 4'b0010;
        a_v[1] = 32'h0001_0000;
        b_v[1] = 32'h0001_0000;
        tick();
        a_v[1] = 32'hFFFF_FFFF;
        b_v[1] = 32'hFFFF_FFFF;
        tick();
        req_valid = 4'h0;
        repeat (5) tick();
        checks++;
        if (res_q.size() != 2) begin
            errors++;
            $display("FAIL ovf_count: got %0d need 2", res_q.size());
        end
        for (int i = 0; i < 2 && i < res_q.size(); i++) begin
            checks++;
            if (res_q[i].gdata !== need[i] || res_q[i].gid !== 2'd1) begin
                errors++;
                $display("FAIL ovf_data[%0d]: got id=%0d data=%h need id=1 data=%h",
                         i, res_q[i].gid, res_q[i].gdata, need[i]);
            end
        end
    endtask

    task automatic test_simul_push_pop();
        clear_logs();
        resp_ready = 1'b0;
        req_valid = 4'b1000;
        b_v[3] = 32'd5;
        for (int k = 1; k <= 3; k++) begin
            a_v[3] = 32'(k);
            tick();
        end
        req_valid = 4'h0;
        repeat (3) tick();
        checks++;
        if (dut.fifo_count_q !== 4'd3) begin
            errors++;
            $display("FAIL spp_fill: count got %0d need 3", dut.fifo_count_q);
        end
        a_v[3] = 32'd4;
        req_valid = 4'b1000;
        tick();
        req_valid = 4'h0;
        resp_ready = 1'b1;
        tick();
        checks++;
        if (dut.fifo_count_q !== 4'd3) begin
            errors++;
            $display("FAIL spp_count: got %0d need 3 after push+pop", dut.fifo_count_q);
        end
        repeat (6) tick();
        checks++;
        if (res_q.size() != 4) begin
            errors++;
            $display("FAIL spp_resp_count: got %0d need 4", res_q.size());
        end
        for (int i = 0; i < res_q.size(); i++) begin
            checks++;
            if (res_q[i].extra || res_q[i].gdata !== 32'(5 * (i + 1)) || res_q[i].gid !== 2'd3) begin
                errors++;
                $display("FAIL spp_order[%0d]: got id=%0d data=%h need id=3 data=%h",
                         i, res_q[i].gid, res_q[i].gdata, 32'(5 * (i + 1)));
            end
        end
    endtask

    task automatic test_reset_midop();
        clear_logs();
        resp_ready = 1'b0;
        req_valid = 4'b0100;
        for (int k = 1; k <= 3; k++) begin
            a_v[2] = 32'(k);
            b_v[2] = 32'd9;
            tick();
        end
        req_valid = 4'hF;
        checks++;
        if (resp_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL midop_pre: got rv=%b busy=%b need 1 1", resp_valid, busy);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (resp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0 ||
            resp_data !== 32'd0 || resp_id !== 2'd0) begin
            errors++;
            $display("FAIL midop_reset: got rv=%b busy=%b ready=%b id=%0d data=%h need zeros",
                     resp_valid, busy, req_ready, resp_id, resp_data);
        end
        exp_q.delete();
        #2;
        reset = 1'b1;
        resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_v[i] = 32'(100 + i);
            b_v[i] = 32'd2;
        end
        clear_logs();
        tick();
        req_valid = 4'h0;
        repeat (8) tick();
        checks++;
        if (acc_q.size() != 1 || acc_q[0] != 0) begin
            errors++;
            $display("FAIL midop_first_grant: got %0d accepts first=%0d need 1 accept to 0",
                     acc_q.size(), acc_q.size() > 0 ? acc_q[0] : -1);
        end
        checks++;
        if (res_q.size() != 1 || res_q[0].extra || res_q[0].gid !== 2'd0 ||
            res_q[0].gdata !== 32'd200) begin
            errors++;
            $display("FAIL midop_stale: got %0d responses, need one id=0 data=000000c8",
                     res_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_backpressure();
        test_overflow();
        test_simul_push_pop();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter DATA_LEN, default 32: operand and result width.
REQ-002 Parameter NUM_REQ, default 4: number of requesters, minimum 2.
REQ-003 Parameter MULT_LATENCY, default 1: register stages inside the shared multiplier.
REQ-004 Parameter FIFO_DEPTH, default 4: response buffer entries, at least MULT_LATENCY+1.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 req_valid  in  NUM_REQ  per-requester operation request.
REQ-008 req_ready  out  NUM_REQ  per-requester accept, one-hot or zero.
REQ-009 req_a  in  NUM_REQ*DATA_LEN  packed operand A, requester i in slice i.
REQ-010 req_b  in  NUM_REQ*DATA_LEN  packed operand B, requester i in slice i.
REQ-011 resp_valid  out  1  response available.
REQ-012 resp_ready  in  1  consumer accepts response.
REQ-013 resp_id  out  ID_W  requester index of the response; ID_W = clog2(NUM_REQ).
REQ-014 resp_data  out  DATA_LEN  low DATA_LEN bits of the signed product.
REQ-015 busy  out  1  high while any operation is in flight or buffered.

Function
REQ-016 A request is accepted in a cycle where req_valid[i] and req_ready[i] are both high.
REQ-017 At most one req_ready bit shall be high per cycle.
REQ-018 req_ready[i] shall be high only when req_valid[i] is high and issue is permitted.
REQ-019 Issue is permitted when (fifo_count + inflight_count) < FIFO_DEPTH.
REQ-020 Arbitration is round-robin: search starts at the index after the last granted requester, wrapping from NUM_REQ-1 to 0.
REQ-021 The round-robin pointer updates only on accept; otherwise it holds.
REQ-022 Accepted operands go to the multiplier in the accept cycle; the requester index travels in a MULT_LATENCY-deep valid/id shift pipeline aligned to the multiplier output.
REQ-023 The multiplier result and id are pushed into the response FIFO when the tag pipeline output is valid.
REQ-024 resp_valid is high whenever the FIFO is non-empty; resp_id and resp_data show the FIFO head.
REQ-025 A pop occurs when resp_valid and resp_ready are both high.
REQ-026 Push and pop in the same cycle leave fifo_count unchanged; the push never overflows, which REQ-019 guarantees.
REQ-027 Minimum latency from accept to resp_valid is MULT_LATENCY+1 cycles.
REQ-028 With resp_ready held high, one accept per cycle is sustained.
REQ-029 Responses appear in accept order, for all requesters combined.
REQ-030 busy = (inflight_count != 0) or (fifo_count != 0).
REQ-031 FIFO read and write pointers wrap modulo FIFO_DEPTH; FIFO_DEPTH need not be a power of two.
REQ-032 An accepted request is never dropped or duplicated while reset is deasserted.

Reset
REQ-033 Asserting reset immediately clears:
  - the FIFO, its pointers and count
  - the tag pipeline
  - the round-robin pointer, set to requester 0
REQ-034 During reset, req_ready = 0, resp_valid = 0, resp_id = 0, resp_data = 0 and busy = 0.
REQ-035 Reset mid-operation discards all in-flight and buffered results; no response is produced for them after reset.
REQ-036 The multiplier reset input is driven from the inverted reset.

Structure
REQ-037 A shared package holds:
  - the ID_W derivation function
  - the default DATA_LEN, NUM_REQ, MULT_LATENCY and FIFO_DEPTH constants
REQ-038 The single sub-module is the existing pipelined multiplier, instantiated once.
REQ-039 The arbiter, tag pipeline and FIFO are inline logic in mult_arbiter.

Verification
REQ-040 Single request: requester 2 sends a=7, b=-3 with resp_ready high -> resp_valid 2 cycles later with resp_id=2 and resp_data=0xFFFFFFEB.
REQ-041 All four requesters held valid with resp_ready high -> grants in order 0,1,2,3,0 on consecutive cycles, and resp_id follows the same sequence.
REQ-042 resp_ready held low, requester 0 continuously valid -> exactly FIFO_DEPTH=4 accepts, then req_ready stays 0; raising resp_ready -> 4 responses in order, then accepts resume.
REQ-043 Overflow: a=0x10000, b=0x10000 -> resp_data=0x00000000; a=-1, b=-1 -> resp_data=1.
REQ-044 Reset asserted with 2 entries buffered and 1 in flight -> resp_valid and busy drop immediately; after release, no stale response appears and the first grant goes to requester 0.
REQ-045 Simultaneous push and pop with the FIFO at count 3 -> count stays 3, and resp_data order is preserved.
